// File: rtl/mmcm_drp_sequencer_if.sv
// DRP port between the reconfiguration sequencer (master)
// and the MMCM dynamic reconfiguration port (slave).
interface mmcm_drp_sequencer_if;
    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;

    modport master (
        output drp_daddr, drp_den, drp_dwe, drp_di,
        input  drp_do, drp_drdy
    );

    modport slave (
        input  drp_daddr, drp_den, drp_dwe, drp_di,
        output drp_do, drp_drdy
    );
endinterface

// File: rtl/mmcm_drp_sequencer.sv
// MMCM reconfiguration via DRP read-modify-write table walk,
// with lock-gated release of the downstream user reset.
module mmcm_drp_sequencer #(
    parameter int TABLE_DEPTH  = 8,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int RST_HOLD     = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [$clog2(TABLE_DEPTH):0]   entry_count,
    output logic [$clog2(TABLE_DEPTH)-1:0] tbl_idx,
    input  logic [6:0]                     tbl_addr,
    input  logic [15:0]                    tbl_mask,
    input  logic [15:0]                    tbl_data,
    mmcm_drp_sequencer_if.master           drp,
    output logic                           mmcm_rst,
    input  logic                           mmcm_locked,
    output logic                           user_reset,
    output logic                           busy,
    output logic                           done,
    output logic                           error
);
    localparam int IW = $clog2(TABLE_DEPTH);
    localparam int CM1 = (DRDY_TIMEOUT > LOCK_TIMEOUT)
                         ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int CMAX = (CM1 > RST_HOLD) ? CM1 : RST_HOLD;
    localparam int CW = $clog2(CMAX + 1);

    localparam logic [CW-1:0] CNT_SAT  = CW'(CMAX);
    localparam logic [CW-1:0] HOLD_END = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] DRDY_END = CW'(DRDY_TIMEOUT - 1);
    localparam logic [CW-1:0] LOCK_END = CW'(LOCK_TIMEOUT - 1);
    localparam logic [IW:0]   DEPTH    = (IW + 1)'(TABLE_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HOLD_RST,
        S_RD,
        S_WAIT_RD,
        S_WR,
        S_WAIT_WR,
        S_NEXT,
        S_RELEASE,
        S_WAIT_LOCK
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_d;
    logic [IW-1:0] last_q, last_d;
    logic [15:0]   rd_q, rd_d;
    logic [6:0]    daddr_q, daddr_d;
    logic          den_q, den_d;
    logic          dwe_q, dwe_d;
    logic [15:0]   di_q, di_d;
    logic          mrst_d, urst_d;
    logic          busy_d, done_d, err_d;
    logic          lock_meta, lock_sync;
    logic          cnt_valid;

    assign drp.drp_daddr = daddr_q;
    assign drp.drp_den   = den_q;
    assign drp.drp_dwe   = dwe_q;
    assign drp.drp_di    = di_q;

    assign cnt_valid = (entry_count != '0)
                    && (entry_count <= DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= mmcm_locked;
            lock_sync <= lock_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tbl_idx    <= '0;
            last_q     <= '0;
            rd_q       <= '0;
            daddr_q    <= '0;
            den_q      <= 1'b0;
            dwe_q      <= 1'b0;
            di_q       <= '0;
            mmcm_rst   <= 1'b0;
            user_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tbl_idx    <= idx_d;
            last_q     <= last_d;
            rd_q       <= rd_d;
            daddr_q    <= daddr_d;
            den_q      <= den_d;
            dwe_q      <= dwe_d;
            di_q       <= di_d;
            mmcm_rst   <= mrst_d;
            user_reset <= urst_d;
            busy       <= busy_d;
            done       <= done_d;
            error      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        idx_d   = tbl_idx;
        last_d  = last_q;
        rd_d    = rd_q;
        daddr_d = daddr_q;
        den_d   = 1'b0;
        dwe_d   = 1'b0;
        di_d    = di_q;
        mrst_d  = mmcm_rst;
        urst_d  = user_reset;
        done_d  = 1'b0;
        err_d   = error;

        unique case (state_q)
            S_IDLE: begin
                // outside a request the user reset follows lock
                urst_d = ~lock_sync;
                if (start && cnt_valid) begin
                    state_d = S_HOLD_RST;
                    cnt_d   = '0;
                    idx_d   = '0;
                    last_d  = IW'(entry_count - 1'b1);
                    mrst_d  = 1'b1;
                    urst_d  = 1'b1;
                    err_d   = 1'b0;
                end else if (start) begin
                    err_d  = 1'b1;
                    done_d = 1'b1;
                end
            end
            S_HOLD_RST: begin
                if (cnt_q == HOLD_END)
                    state_d = S_RD;
            end
            S_RD: begin
                den_d   = 1'b1;
                daddr_d = tbl_addr;
                cnt_d   = '0;
                state_d = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (drp.drp_drdy) begin
                    rd_d    = drp.drp_do;
                    state_d = S_WR;
                end else if (cnt_q == DRDY_END) begin
                    err_d   = 1'b1;
                    mrst_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WAIT_LOCK;
                end
            end
            S_WR: begin
                den_d   = 1'b1;
                dwe_d   = 1'b1;
                daddr_d = tbl_addr;
                di_d    = (rd_q & tbl_mask)
                        | (tbl_data & ~tbl_mask);
                cnt_d   = '0;
                state_d = S_WAIT_WR;
            end
            S_WAIT_WR: begin
                if (drp.drp_drdy) begin
                    state_d = S_NEXT;
                end else if (cnt_q == DRDY_END) begin
                    err_d   = 1'b1;
                    mrst_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WAIT_LOCK;
                end
            end
            S_NEXT: begin
                if (tbl_idx == last_q) begin
                    state_d = S_RELEASE;
                end else begin
                    idx_d   = tbl_idx + 1'b1;
                    state_d = S_RD;
                end
            end
            S_RELEASE: begin
                mrst_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_sync) begin
                    urst_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == LOCK_END) begin
                    // leave user_reset high; IDLE tracking frees it
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end
endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Bench for mmcm_drp_sequencer: DRP/MMCM behavioural models and
// a table-level read-modify-write reference for random tables.
`timescale 1ns/1ps
module tb_mmcm_drp_sequencer;
    localparam int TD = 8;
    localparam int DT = 64;
    localparam int LT = 200;
    localparam int RH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  entry_count = '0;
    logic [2:0]  tbl_idx;
    logic [6:0]  tbl_addr;
    logic [15:0] tbl_mask;
    logic [15:0] tbl_data;
    logic        mmcm_rst;
    logic        mmcm_locked = 1'b0;
    logic        user_reset, busy, done, error;

    mmcm_drp_sequencer_if drp ();

    logic [6:0]  tab_a [TD];
    logic [15:0] tab_m [TD];
    logic [15:0] tab_d [TD];

    assign tbl_addr = tab_a[tbl_idx];
    assign tbl_mask = tab_m[tbl_idx];
    assign tbl_data = tab_d[tbl_idx];

    mmcm_drp_sequencer #(
        .TABLE_DEPTH (TD),
        .DRDY_TIMEOUT(DT),
        .LOCK_TIMEOUT(LT),
        .RST_HOLD    (RH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .entry_count(entry_count),
        .tbl_idx    (tbl_idx),
        .tbl_addr   (tbl_addr),
        .tbl_mask   (tbl_mask),
        .tbl_data   (tbl_data),
        .drp        (drp),
        .mmcm_rst   (mmcm_rst),
        .mmcm_locked(mmcm_locked),
        .user_reset (user_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    // DRP slave: register file with programmable DRDY latency
    logic [15:0] mem [128];
    int          lat = 1;
    bit          mute = 0;
    bit          pend = 0;
    int          dly = 0;
    int          den_cyc [$];
    logic [6:0]  rd_log [$];
    logic [22:0] wr_log [$];
    int          rst_viol = 0;
    int          done_cnt = 0;

    always @(posedge clk) begin
        #1;
        drp.drp_drdy = 1'b0;
        if (pend) begin
            if (dly <= 1) begin
                drp.drp_drdy = 1'b1;
                pend = 0;
            end else begin
                dly--;
            end
        end
        if (drp.drp_den === 1'b1) begin
            den_cyc.push_back(cyc);
            if (mmcm_rst !== 1'b1) rst_viol++;
            if (drp.drp_dwe) begin
                wr_log.push_back({drp.drp_daddr, drp.drp_di});
                mem[drp.drp_daddr] = drp.drp_di;
            end else begin
                rd_log.push_back(drp.drp_daddr);
                drp.drp_do = mem[drp.drp_daddr];
            end
            pend = !mute;
            dly = lat;
        end
        if (done === 1'b1) done_cnt++;
    end

    // MMCM lock model: lock lock_dly cycles after reset release
    bit lock_en = 0;
    int lock_dly = 20;
    int lk_cnt = 0;
    int lock_rise = -1;

    always @(posedge clk) begin
        #1;
        if (mmcm_rst !== 1'b0 || !lock_en) begin
            mmcm_locked = 1'b0;
            lk_cnt = 0;
        end else if (lk_cnt >= lock_dly) begin
            if (!mmcm_locked) lock_rise = cyc;
            mmcm_locked = 1'b1;
        end else begin
            lk_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input int n, output int at);
        @(negedge clk);
        start = 1'b1;
        entry_count = 4'(n);
        @(negedge clk);
        start = 1'b0;
        at = cyc;
    endtask

    // sel: 0 done, 1 locked, 2 error, 3 mmcm_rst low
    task automatic wait_for(input int sel, input int lim,
                            output int at);
        at = -1;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if ((sel == 0 && done === 1'b1) ||
                (sel == 1 && mmcm_locked === 1'b1) ||
                (sel == 2 && error === 1'b1) ||
                (sel == 3 && mmcm_rst === 1'b0)) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_mmcm_rst"}, 32'(mmcm_rst), 0);
        chk({p, "_user_reset"}, 32'(user_reset), 1);
        chk({p, "_busy"}, 32'(busy), 0);
        chk({p, "_done"}, 32'(done), 0);
        chk({p, "_error"}, 32'(error), 0);
        chk({p, "_den"}, 32'(drp.drp_den), 0);
        chk({p, "_dwe"}, 32'(drp.drp_dwe), 0);
        chk({p, "_daddr"}, 32'(drp.drp_daddr), 0);
        chk({p, "_di"}, 32'(drp.drp_di), 0);
        chk({p, "_tbl_idx"}, 32'(tbl_idx), 0);
    endtask

    logic [15:0] exp_mem [128];
    logic [22:0] exp_wr [$];
    int          bad [2] = '{0, 9};
    int          t_acc, t_a, t_b, n0, r0, n;
    logic [15:0] rv, wv;

    initial begin
        drp.drp_drdy = 1'b0;
        drp.drp_do = '0;
        for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < TD; i++) begin
            tab_a[i] = '0;
            tab_m[i] = '0;
            tab_d[i] = '0;
        end

        // power-on
        step(3);
        chk_reset("rst");
        reset = 1'b0;
        lock_en = 1;
        lock_dly = 100;
        wait_for(1, 300, t_a);
        chk("por_lock_seen", 32'(t_a >= 0), 1);
        step(2);
        chk("por_ur_hold", 32'(user_reset), 1);
        step(1);
        chk("por_ur_release", 32'(user_reset), 0);
        chk("por_busy", 32'(busy), 0);
        chk("por_no_done", 32'(done_cnt), 0);

        // two-entry directed reconfig
        lock_dly = 20;
        mem[8] = 16'h1FFF;
        mem[9] = 16'h1FFF;
        tab_a[0] = 7'h08; tab_m[0] = 16'h1000; tab_d[0] = 16'h0145;
        tab_a[1] = 7'h09; tab_m[1] = 16'h8000; tab_d[1] = 16'h0000;
        lat = 1;
        den_cyc.delete();
        rd_log.delete();
        wr_log.delete();
        pulse_start(2, t_acc);
        chk("rc_busy", 32'(busy), 1);
        chk("rc_mmcm_rst", 32'(mmcm_rst), 1);
        chk("rc_ur", 32'(user_reset), 1);
        wait_for(0, 400, t_b);
        chk("rc_done_seen", 32'(t_b >= 0), 1);
        chk("rc_den_count", den_cyc.size(), 4);
        chk("rc_first_den", den_cyc[0] - t_acc, RH + 1);
        chk("rc_wr_den", den_cyc[1] - den_cyc[0], 3);
        chk("rc_entry_cycles", den_cyc[2] - den_cyc[0], 7);
        chk("rc_rd0", 32'(rd_log[0]), 32'h08);
        chk("rc_rd1", 32'(rd_log[1]), 32'h09);
        chk("rc_wr0", 32'(wr_log[0]), {9'd0, 7'h08, 16'h1145});
        chk("rc_wr1", 32'(wr_log[1]), {9'd0, 7'h09, 16'h0000});
        chk("rc_done_after_lock", t_b - lock_rise, 3);
        chk("rc_error", 32'(error), 0);
        chk("rc_ur_low", 32'(user_reset), 0);
        step(1);
        chk("rc_done_pulse", 32'(done), 0);
        chk("rc_idle", 32'(busy), 0);

        // invalid entry counts
        for (int i = 0; i < 2; i++) begin
            n0 = den_cyc.size();
            pulse_start(bad[i], t_acc);
            chk("bad_done", 32'(done), 1);
            chk("bad_error", 32'(error), 1);
            chk("bad_busy", 32'(busy), 0);
            chk("bad_mmcm_rst", 32'(mmcm_rst), 0);
            chk("bad_ur", 32'(user_reset), 0);
            step(1);
            chk("bad_done_pulse", 32'(done), 0);
            chk("bad_error_sticky", 32'(error), 1);
            step(3);
            chk("bad_no_den", den_cyc.size(), n0);
        end

        // DRDY never arrives on the first read
        mute = 1;
        tab_a[0] = 7'h20;
        n0 = den_cyc.size();
        pulse_start(1, t_acc);
        chk("to_error_cleared", 32'(error), 0);
        wait_for(2, 200, t_b);
        chk("to_error_seen", 32'(t_b >= 0), 1);
        chk("to_latency", t_b - den_cyc[n0], DT);
        chk("to_mmcm_rst", 32'(mmcm_rst), 0);
        chk("to_ur", 32'(user_reset), 1);
        mute = 0;
        wait_for(0, 200, t_b);
        chk("to_done_seen", 32'(t_b >= 0), 1);
        chk("to_error_held", 32'(error), 1);
        chk("to_ur_low", 32'(user_reset), 0);
        chk("to_single_den", den_cyc.size(), n0 + 1);

        // lock never returns
        lock_en = 0;
        pulse_start(1, t_acc);
        wait_for(3, 200, t_a);
        chk("lk_release_seen", 32'(t_a >= 0), 1);
        wait_for(0, 400, t_b);
        chk("lk_done_seen", 32'(t_b >= 0), 1);
        chk("lk_latency", t_b - t_a, LT);
        chk("lk_error", 32'(error), 1);
        chk("lk_ur", 32'(user_reset), 1);
        chk("lk_busy", 32'(busy), 0);
        step(1);
        chk("lk_ur_hold", 32'(user_reset), 1);
        lock_en = 1;
        wait_for(1, 100, t_a);
        chk("lk_relock_seen", 32'(t_a >= 0), 1);
        step(2);
        chk("lk_ur_still", 32'(user_reset), 1);
        step(1);
        chk("lk_ur_release", 32'(user_reset), 0);

        // start while busy is ignored
        lat = 2;
        for (int i = 0; i < 2; i++) begin
            tab_a[i] = 7'($urandom);
            tab_m[i] = 16'($urandom);
            tab_d[i] = 16'($urandom);
        end
        n0 = wr_log.size();
        done_cnt = 0;
        pulse_start(2, t_acc);
        step(8);
        pulse_start(5, t_a);
        wait_for(0, 400, t_b);
        chk("ign_done_seen", 32'(t_b >= 0), 1);
        step(3);
        chk("ign_writes", wr_log.size() - n0, 2);
        chk("ign_one_done", done_cnt, 1);
        chk("ign_error", 32'(error), 0);

        // random tables against the table-level reference
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, TD);
            lat = $urandom_range(1, 5);
            exp_mem = mem;
            exp_wr.delete();
            for (int i = 0; i < n; i++) begin
                tab_a[i] = 7'($urandom);
                tab_m[i] = 16'($urandom);
                tab_d[i] = 16'($urandom);
                rv = exp_mem[tab_a[i]];
                wv = (rv & tab_m[i]) | (tab_d[i] & ~tab_m[i]);
                exp_mem[tab_a[i]] = wv;
                exp_wr.push_back({tab_a[i], wv});
            end
            n0 = wr_log.size();
            r0 = rd_log.size();
            pulse_start(n, t_acc);
            wait_for(0, 1000, t_b);
            chk("rnd_done_seen", 32'(t_b >= 0), 1);
            chk("rnd_writes", wr_log.size() - n0, n);
            for (int i = 0; i < n; i++) begin
                chk("rnd_rd", 32'(rd_log[r0 + i]), 32'(tab_a[i]));
                chk("rnd_wr", 32'(wr_log[n0 + i]), 32'(exp_wr[i]));
            end
            chk("rnd_error", 32'(error), 0);
            chk("rnd_ur", 32'(user_reset), 0);
        end

        // asynchronous reset during WAIT_WR
        lat = 4;
        tab_a[0] = 7'h11;
        pulse_start(1, t_acc);
        t_a = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (drp.drp_den === 1'b1 && drp.drp_dwe === 1'b1) begin
                t_a = cyc;
                break;
            end
        end
        chk("ar_wr_strobe_seen", 32'(t_a >= 0), 1);
        reset = 1'b1;
        #1;
        chk_reset("ar");
        step(2);
        reset = 1'b0;
        wait_for(1, 100, t_a);
        chk("ar_relock_seen", 32'(t_a >= 0), 1);
        step(3);
        chk("ar_ur_release", 32'(user_reset), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("drp_under_mmcm_rst", rst_viol, 0);

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mmcm_drp_sequencer.md
# mmcm_drp_sequencer

Reconfiguration controller for the fabric clock MMCM that derives the user-logic clock from the board oscillator. On a start request it holds the MMCM in reset and walks a small table of read-modify-write operations over the MMCM DRP port. It then releases the MMCM, waits for lock, and only then releases the reset to the downstream user logic. It also owns the power-on reset for that logic, keeping it asserted until the MMCM first reports lock.

## Interface

- TABLE_DEPTH, 8: maximum number of DRP table entries (power of two).
- DRDY_TIMEOUT, 64: cycles allowed between drp_den and drp_drdy.
- LOCK_TIMEOUT, 65535: cycles allowed between mmcm_rst release and synchronized lock.
- RST_HOLD, 4: cycles mmcm_rst is held before the first DRP access.
- clk  in  1  DRP clock; all logic on rising edge. Reset is asynchronous, active-high.
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle request; accepted only in IDLE.
- entry_count  in  log2(TABLE_DEPTH)+1  number of table entries to apply; sampled when start is accepted.
- tbl_idx  out  log2(TABLE_DEPTH)  registered table index.
- tbl_addr  in  7  DRP address for entry tbl_idx; combinational from tbl_idx, valid in the same cycle.
- tbl_mask  in  16  bits set to 1 keep the value read back from the MMCM.
- tbl_data  in  16  new value for bits where tbl_mask is 0.
- drp_daddr  out  7  DRP address.
- drp_den  out  1  DRP enable, single-cycle strobe.
- drp_dwe  out  1  DRP write enable, driven together with drp_den.
- drp_di  out  16  DRP write data.
- drp_do  in  16  DRP read data, valid with drp_drdy.
- drp_drdy  in  1  DRP ready.
- mmcm_rst  out  1  MMCM reset.
- mmcm_locked  in  1  MMCM lock; asynchronous, passed through a 2-flop synchronizer internally.
- user_reset  out  1  active-high reset to downstream user logic.
- busy  out  1  high in any state other than IDLE.
- done  out  1  single-cycle pulse at the end of every accepted request.
- error  out  1  sticky; cleared when the next start is accepted.

## Operation

- States and transitions:
  - IDLE -> HOLD_RST (on accepted start): load entry counter, zero tbl_idx, assert mmcm_rst and user_reset, clear error.
  - HOLD_RST -> RD after RST_HOLD cycles.
  - RD: one-cycle strobe with drp_den=1, drp_dwe=0, drp_daddr=tbl_addr; then -> WAIT_RD.
  - WAIT_RD: on drp_drdy, latch drp_do and go -> WR.
  - WR: one-cycle strobe with drp_den=1, drp_dwe=1, same address, drp_di = (rd & tbl_mask) | (tbl_data & ~tbl_mask); then -> WAIT_WR.
  - WAIT_WR: on drp_drdy, -> NEXT.
  - NEXT: if tbl_idx == entry_count-1 -> RELEASE; else increment tbl_idx and go -> RD.
  - RELEASE: deassert mmcm_rst, clear the timeout counter, -> WAIT_LOCK.
  - WAIT_LOCK: on synchronized lock high, deassert user_reset, pulse done, -> IDLE.
- Timeouts:
  - DRDY timeout in WAIT_RD or WAIT_WR: set error, deassert mmcm_rst, go -> WAIT_LOCK. The MMCM is never left held in reset.
  - LOCK timeout: set error, pulse done, -> IDLE with user_reset still high. Power-on lock tracking in IDLE keeps watching and releases user_reset when lock appears.
- Invalid entry_count (0 or > TABLE_DEPTH): set error and pulse done one cycle after start; mmcm_rst and user_reset are untouched and no DRP access occurs.
- Power-on: user_reset stays high until synchronized lock is seen in IDLE, then drops. In IDLE, a later loss of lock reasserts user_reset.
- start while busy is ignored, with no queuing.
- drp_drdy outside WAIT_RD/WAIT_WR is ignored.

## Timing

- Reset values: state IDLE, mmcm_rst 0, user_reset 1, drp_den 0, drp_dwe 0, drp_daddr 0, drp_di 0, tbl_idx 0, busy 0, done 0, error 0.
- All outputs are registered.
- Lock synchronizer latency is 2 cycles; user_reset falls on the 3rd edge after mmcm_locked rises.
- start seen at edge N: busy and mmcm_rst are high after edge N.
- First drp_den occurs RST_HOLD+1 cycles after accept.
- Each entry takes 2 strobes + 2 DRDY waits + 1 NEXT cycle; with a 1-cycle DRDY, that is 7 cycles per entry.
- Counters saturate and do not wrap; the timeout is detected when the count reaches the parameter value.
- An asynchronous reset mid-sequence returns to IDLE with the reset values above, including mmcm_rst=0, so the MMCM relocks on its current DRP contents.

## Test plan

- Power-on: mmcm_locked rises 100 cycles after reset drops -> user_reset falls exactly 3 cycles later; busy=0, done=0.
- Two-entry reconfig: entries {0x08, mask 0x1000, data 0x0145} and {0x09, mask 0x8000, data 0x0000}; DRP model returns 0x1FFF for both, DRDY 1 cycle -> writes 0x1145 then 0x0000; mmcm_rst high throughout; done pulses 3 cycles after lock; error=0.
- entry_count=0, then entry_count=9 with TABLE_DEPTH=8 -> error=1 and done pulse one cycle after start; no drp_den; mmcm_rst stays 0.
- DRDY never asserts on the first read -> after 64 cycles error=1 and mmcm_rst=0; sequence completes through WAIT_LOCK once lock returns.
- Lock never returns, with LOCK_TIMEOUT=200 -> done and error at cycle 200 after RELEASE, user_reset still 1; lock rising later drops user_reset 3 cycles after.
- Start pulse mid-sequence is ignored (entry counter unchanged). Reset asserted during WAIT_WR -> all outputs immediately take their reset values.
